// File: rtl/cybercobra_hex_display.sv
// cybercobra_hex_display
// Multiplexed common-anode 7-segment driver for the CYBERcobra out_o word.
// The displayed word is captured into a shadow register once per full scan
// frame, so a digit never changes in the middle of a frame.
//
// Parameters:
//   DIGITS       number of hex digits (1..8); digit k shows value[4k+3:4k]
//   REFRESH_DIV  clk cycles each digit stays lit (>=2)
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   value_i        word to display
//   hold_i         1 = skip frame loads, keep the shadow value
//   an_o           digit enables, active-low, one-hot-zero
//   seg_o          segments {g,f,e,d,c,b,a}, active-low
//   dp_o           decimal point, active-low, always off
//   frame_start_o  1-cycle pulse on the cycle after the shadow loads
// Configuration:
//   HEX_DISPLAY_ZERO_BLANK_EN  when defined, leading-zero digits (k>0) are blanked.
module cybercobra_hex_display #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       value_i,
  input  logic              hold_i,
  output logic [DIGITS-1:0] an_o,
  output logic [6:0]        seg_o,
  output logic              dp_o,
  output logic              frame_start_o
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = 4 * DIGITS;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]            prescaler;
  logic [IW-1:0]            digit_idx;
  logic [SW-1:0]            shadow;
  logic                     load_pending;
  logic                     tick, frame_end, load;
  logic [DIGITS-1:0][3:0]   nib;
  logic [DIGITS-1:0]        lead_zero;
  logic [DIGITS-1:0]        an_next;
  logic [6:0]               seg_next;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;  4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;  4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;  4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;  4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;  4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;  4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;  4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;  default: hex_glyph = 7'h0E;
    endcase
  endfunction

  assign tick      = (prescaler == PRE_LAST);
  assign frame_end = tick && (digit_idx == IDX_LAST);
  // load_pending makes the first cycle after reset load even mid-scan.
  assign load      = (frame_end || load_pending) && !hold_i;
  assign nib       = shadow;
  assign dp_o      = 1'b1;

  // lead_zero[k]: every nibble from k upward is zero; digit 0 never qualifies.
  for (genvar k = 0; k < DIGITS; k++) begin : g_lz
    if (k == 0) begin : g_d0
      assign lead_zero[k] = 1'b0;
    end else begin : g_dk
      assign lead_zero[k] = ~|shadow[SW-1:4*k];
    end
  end

  always_comb begin
    an_next  = ~(DIGITS'(1) << digit_idx);
    seg_next = hex_glyph(nib[digit_idx]);
`ifdef HEX_DISPLAY_ZERO_BLANK_EN
    if (lead_zero[digit_idx]) begin
      an_next  = '1;
      seg_next = 7'h7F;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prescaler     <= '0;
      digit_idx     <= '0;
      shadow        <= '0;
      load_pending  <= 1'b1;
      an_o          <= '1;
      seg_o         <= 7'h7F;
      frame_start_o <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IW'(1);
      if (load) begin
        shadow       <= value_i[SW-1:0];
        load_pending <= 1'b0;
      end
      frame_start_o <= load;
      an_o          <= an_next;
      seg_o         <= seg_next;
    end
  end

  logic unused_lz;
  assign unused_lz = ^lead_zero;
endmodule

// File: tb/tb_cybercobra_hex_display.sv
module tb_cybercobra_hex_display;
  localparam int D = 8;
  localparam int R = 4;
  localparam logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] value = '0;
  logic        hold = 0;
  logic [D-1:0] an;
  logic [6:0]  seg;
  logic        dp, fs;

  int n_chk = 0, n_pass = 0;

  // Reference state: cycles since reset release, shadowed word, pending flag.
  int          cyc = 0;
  logic [31:0] sh_m = '0;
  bit          pend_m = 1;

  cybercobra_hex_display #(.DIGITS(D), .REFRESH_DIV(R)) dut (
    .clk_i(clk), .rst_i(rst), .value_i(value), .hold_i(hold),
    .an_o(an), .seg_o(seg), .dp_o(dp), .frame_start_o(fs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
  endtask

  // One clock: compare registered outputs against the reference, then advance it.
  task automatic step();
    logic [31:0] e_an, e_seg;
    bit          e_fs, fe;
    int          dig;
    @(posedge clk);
    #1;
    if (rst) begin
      e_an = 32'hFF; e_seg = 32'h7F; e_fs = 0;
      cyc = 0; sh_m = '0; pend_m = 1;
    end else begin
      dig   = (cyc / R) % D;
      fe    = (cyc % (R * D)) == (R * D - 1);
      e_an  = 32'hFF & ~(32'd1 << dig);
      e_seg = {25'd0, GLY[(sh_m >> (4 * dig)) & 32'hF]};
`ifdef HEX_DISPLAY_ZERO_BLANK_EN
      if (dig > 0 && (sh_m >> (4 * dig)) == 0) begin
        e_an = 32'hFF; e_seg = 32'h7F;
      end
`endif
      e_fs = (fe || pend_m) && !hold;
      if (e_fs) begin
        sh_m = value; pend_m = 0;
      end
      cyc++;
    end
    chk("an", {24'd0, an}, e_an);
    chk("seg", {25'd0, seg}, e_seg);
    chk("dp", {31'd0, dp}, 32'd1);
    chk("frame_start", {31'd0, fs}, {31'd0, e_fs});
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    // reset
    rst = 1; run(2);
    rst = 0; value = 32'h0000_0204; run(40);
    // glyph coverage
    value = 32'h89AB_CDEF; run(40);
    // tearing: change mid-frame
    run(10); value = 32'hFFFF_FFFF; run(60);
    // hold across two frame ends
    hold = 1; value = 32'h1234_5678; run(72);
    hold = 0; run(40);
    // zero value
    value = 32'h0; run(40);
    // mid-frame reset
    value = 32'h0000_0ABC; run(13);
    rst = 1; run(1); rst = 0; run(20);
    // hold asserted on the first cycle after release
    rst = 1; run(1); hold = 1; rst = 0; run(5); hold = 0; run(40);
    // random mix, with many leading-zero values
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) value = $urandom >> $urandom_range(0, 31);
      hold = ($urandom_range(0, 7) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
